// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, control bundle layout,
// ALU op encodings and stage FSM states.
package decode_stage_pkg;

  localparam int CTRL_W = 12;

  localparam int C_REG2LOC  = 0;
  localparam int C_ALUSRC   = 1;
  localparam int C_MEM2REG  = 2;
  localparam int C_REGWR    = 3;
  localparam int C_MEMRD    = 4;
  localparam int C_MEMWR    = 5;
  localparam int C_ZBR      = 6;
  localparam int C_UBR      = 7;
  localparam int C_ALUOP    = 8;
  localparam int C_USESP    = 10;
  localparam int C_SETFLAGS = 11;

  localparam logic [1:0] ALU_PASS  = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_ARITH = 2'b10;

  localparam logic [7:0]  HLT_OP  = 8'hD4;
  localparam logic [7:0]  CBZ_OP  = 8'hB4;
  localparam logic [5:0]  B_OP    = 6'h05;
  localparam logic [8:0]  MOVZ_OP = 9'h1A5;
  localparam logic [8:0]  SUB_OP  = 9'h1A2;
  localparam logic [8:0]  ADD_OP  = 9'h122;
  localparam logic [10:0] CMP_OP  = 11'h758;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } stateT;

endpackage

// File: rtl/decode_stage_ctrl_decode.sv
// Combinational opcode decoder.
// Ports: instr in; ctrl bundle, isHalt, isIllegal out.
module ctrl_decode
  import decode_stage_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic              isHalt,
  output logic              isIllegal
);

  // Operand fields below the opcode are not decoded here.
  logic unusedBits;
  assign unusedBits = ^instr[20:0];

  // Opcode prefixes are mutually disjoint, so the
  // listed priority order is preserved by a unique case.
  always_comb begin
    ctrl      = '0;
    isHalt    = 1'b0;
    isIllegal = 1'b0;
    unique case (1'b1)
      (instr[31:24] == HLT_OP): isHalt = 1'b1;
      (instr[31:24] == CBZ_OP): begin
        ctrl[C_REG2LOC]    = 1'b1;
        ctrl[C_ZBR]        = 1'b1;
        ctrl[C_ALUOP +: 2] = ALU_CMP;
      end
      (instr[31:26] == B_OP): ctrl[C_UBR] = 1'b1;
      (instr[31:23] == MOVZ_OP): begin
        ctrl[C_REGWR]  = 1'b1;
        ctrl[C_ALUSRC] = 1'b1;
      end
      (instr[31:23] == SUB_OP),
      (instr[31:23] == ADD_OP): begin
        ctrl[C_ALUOP +: 2] = ALU_ARITH;
        ctrl[C_ALUSRC]     = 1'b1;
        ctrl[C_REGWR]      = 1'b1;
        ctrl[C_USESP]      = 1'b1;
      end
      (instr[31:21] == CMP_OP): ctrl[C_ALUOP +: 2] = ALU_CMP;
      default: isIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder, output FIFO, halt FSM.
// Ports: in_* from fetch, out_* to execute, flush, pipe_idle,
// resume, halted; illegal when DECODE_ILLEGAL_EN is defined.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               flush,
  input  logic               pipe_idle,
  input  logic               resume,
  output logic               halted
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic               illegal
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [CTRL_W-1:0] decCtrl;
  logic              isHalt;
  logic              isIllegal;

  ctrl_decode uDec (
    .instr     (in_instr[31:0]),
    .ctrl      (decCtrl),
    .isHalt    (isHalt),
    .isIllegal (isIllegal)
  );

  logic [CTRL_W-1:0] ctrlMem [DEPTH];
  logic [ADDR_W-1:0] pcMem   [DEPTH];
  logic [PTR_W:0]    wrPtr;
  logic [PTR_W:0]    rdPtr;
  stateT             state;

  logic empty, full, accept, stopOp, push, pop;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                 (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);

  assign in_ready  = (state == RUN) && !full && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

`ifdef DECODE_ILLEGAL_EN
  assign stopOp = isHalt || isIllegal;
`else
  logic unusedIllegal;
  assign unusedIllegal = isIllegal;
  assign stopOp = isHalt;
`endif

  // Halt/illegal words never enter the queue; flush drops
  // whatever arrives alongside it.
  assign push = accept && !stopOp && !flush;

  // Gate the read port so idle outputs read as zero.
  assign out_ctrl = empty ? '0 : ctrlMem[rdPtr[PTR_W-1:0]];
  assign out_pc   = empty ? '0 : pcMem[rdPtr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      ctrlMem[wrPtr[PTR_W-1:0]] <= decCtrl;
      pcMem[wrPtr[PTR_W-1:0]]   <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (accept && stopOp && !flush) state <= DRAIN;
        end
        DRAIN: begin
          if (empty && pipe_idle) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (resume) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef DECODE_ILLEGAL_EN
  always_ff @(posedge clk) begin
    if (rst) illegal <= 1'b0;
    else if (accept && isIllegal && !flush) illegal <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// Covers stream, backpressure, halt, flush, reset, unmatched opcode.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_ctrl;
  logic [63:0] out_pc;
  logic        flush;
  logic        pipe_idle;
  logic        resume;
  logic        halted;
`ifdef DECODE_ILLEGAL_EN
  logic        illegal;
`endif

  int nChecks = 0;
  int nFail   = 0;

  localparam logic [31:0] I_MOVZ = 32'hD2800020;
  localparam logic [31:0] I_ADD  = 32'h91000421;
  localparam logic [31:0] I_B    = 32'h14000010;
  localparam logic [31:0] I_CBZ  = 32'hB4000040;
  localparam logic [31:0] I_CMP  = 32'hEB01001F;
  localparam logic [31:0] I_HLT  = 32'hD4400000;

  localparam logic [11:0] K_MOVZ = 12'h00A;
  localparam logic [11:0] K_ADD  = 12'h60A;
  localparam logic [11:0] K_B    = 12'h080;
  localparam logic [11:0] K_CBZ  = 12'h141;
  localparam logic [11:0] K_CMP  = 12'h100;

  always #5 clk = ~clk;

  decode_stage #(.INSTR_W(32), .ADDR_W(64), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_pc    (out_pc),
    .flush     (flush),
    .pipe_idle (pipe_idle),
    .resume    (resume),
    .halted    (halted)
`ifdef DECODE_ILLEGAL_EN
    ,
    .illegal   (illegal)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    nChecks++;
    if (in_ready !== 1'b0) begin
      nFail++;
      $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    nChecks++;
    if ({out_valid, out_ctrl, out_pc, halted} !== 78'd0) begin
      nFail++;
      $display("FAIL reset_outputs got v=%b c=%h pc=%h h=%b exp all 0",
               out_valid, out_ctrl, out_pc, halted);
    end
    rst = 1'b0;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFail++;
      $display("FAIL reset_release_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ins [3];
    logic [11:0] exp [3];
    ins[0] = I_MOVZ; ins[1] = I_ADD; ins[2] = I_B;
    exp[0] = K_MOVZ; exp[1] = K_ADD; exp[2] = K_B;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = ins[i];
      in_pc    = 64'h1000 + 64'(4 * i);
      tick();
      nChecks++;
      if ({out_valid, out_ctrl, out_pc} !==
          {1'b1, exp[i], 64'h1000 + 64'(4 * i)}) begin
        nFail++;
        $display("FAIL stream_%0d got v=%b c=%h pc=%h exp v=1 c=%h pc=%h",
                 i, out_valid, out_ctrl, out_pc, exp[i],
                 64'h1000 + 64'(4 * i));
      end
    end
    in_valid = 1'b0;
    tick();
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("FAIL stream_drained got %b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = I_MOVZ; in_pc = 64'h2000;
    tick();
    in_instr  = I_ADD;  in_pc = 64'h2004;
    tick();
    nChecks++;
    if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 64'h2000}) begin
      nFail++;
      $display("FAIL bp_full got rdy=%b v=%b pc=%h exp rdy=0 v=1 pc=2000",
               in_ready, out_valid, out_pc);
    end
    in_instr = I_B; in_pc = 64'h2008;
    tick();
    nChecks++;
    if ({in_ready, out_ctrl, out_pc} !== {1'b0, K_MOVZ, 64'h2000}) begin
      nFail++;
      $display("FAIL bp_hold got rdy=%b c=%h pc=%h exp rdy=0 c=%h pc=2000",
               in_ready, out_ctrl, out_pc, K_MOVZ);
    end
    out_ready = 1'b1;
    tick();
    nChecks++;
    if ({in_ready, out_ctrl, out_pc} !== {1'b1, K_ADD, 64'h2004}) begin
      nFail++;
      $display("FAIL bp_pop1 got rdy=%b c=%h pc=%h exp rdy=1 c=%h pc=2004",
               in_ready, out_ctrl, out_pc, K_ADD);
    end
    tick();
    nChecks++;
    if ({out_valid, out_ctrl, out_pc} !== {1'b1, K_B, 64'h2008}) begin
      nFail++;
      $display("FAIL bp_pop2 got v=%b c=%h pc=%h exp v=1 c=%h pc=2008",
               out_valid, out_ctrl, out_pc, K_B);
    end
    in_valid = 1'b0;
    tick();
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("FAIL bp_empty got %b exp 0", out_valid);
    end
  endtask

  task automatic test_halt();
    out_ready = 1'b0;
    pipe_idle = 1'b0;
    in_valid  = 1'b1;
    in_instr  = I_CBZ; in_pc = 64'h3000;
    tick();
    nChecks++;
    if ({out_valid, out_ctrl, out_pc} !== {1'b1, K_CBZ, 64'h3000}) begin
      nFail++;
      $display("FAIL halt_cbz got v=%b c=%h pc=%h exp v=1 c=%h pc=3000",
               out_valid, out_ctrl, out_pc, K_CBZ);
    end
    in_instr = I_CMP; in_pc = 64'h3004;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = I_HLT; in_pc = 64'h3008;
    tick();
    in_valid = 1'b0;
    nChecks++;
    if ({in_ready, halted, out_valid, out_ctrl, out_pc} !==
        {1'b0, 1'b0, 1'b1, K_CMP, 64'h3004}) begin
      nFail++;
      $display("FAIL halt_drain got rdy=%b h=%b v=%b c=%h pc=%h exp 0 0 1 %h 3004",
               in_ready, halted, out_valid, out_ctrl, out_pc, K_CMP);
    end
    out_ready = 1'b1;
    tick();
    tick();
    nChecks++;
    if ({out_valid, halted, in_ready} !== 3'b000) begin
      nFail++;
      $display("FAIL halt_wait_idle got v=%b h=%b rdy=%b exp 0 0 0",
               out_valid, halted, in_ready);
    end
    pipe_idle = 1'b1;
    tick();
    nChecks++;
    if ({halted, in_ready} !== 2'b10) begin
      nFail++;
      $display("FAIL halt_set got h=%b rdy=%b exp h=1 rdy=0", halted, in_ready);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    nChecks++;
    if ({halted, in_ready} !== 2'b01) begin
      nFail++;
      $display("FAIL halt_resume got h=%b rdy=%b exp h=0 rdy=1", halted, in_ready);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = I_MOVZ; in_pc = 64'h4000;
    tick();
    in_instr  = I_ADD;  in_pc = 64'h4004;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nChecks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      nFail++;
      $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    in_instr = I_MOVZ; in_pc = 64'h4010;
    tick();
    in_instr = I_B; in_pc = 64'h4014;
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("FAIL flush_push got %b exp 0", out_valid);
    end
    tick();
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("FAIL flush_dropped got v=%b pc=%h exp v=0", out_valid, out_pc);
    end
    in_valid = 1'b1;
    in_instr = I_HLT; in_pc = 64'h4020;
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFail++;
      $display("FAIL flush_hlt_run got rdy=%b exp 1", in_ready);
    end
  endtask

  task automatic test_reset_drain();
    out_ready = 1'b0;
    pipe_idle = 1'b0;
    in_valid  = 1'b1;
    in_instr  = I_MOVZ; in_pc = 64'h5000;
    tick();
    in_instr  = I_HLT;  in_pc = 64'h5004;
    tick();
    in_valid = 1'b0;
    nChecks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      nFail++;
      $display("FAIL rstd_drain got rdy=%b v=%b exp 0 1", in_ready, out_valid);
    end
    rst = 1'b1;
    tick();
    nChecks++;
    if ({out_valid, halted, in_ready} !== 3'b000) begin
      nFail++;
      $display("FAIL rstd_clear got v=%b h=%b rdy=%b exp 0 0 0",
               out_valid, halted, in_ready);
    end
    rst = 1'b0;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFail++;
      $display("FAIL rstd_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_unmatched();
    out_ready = 1'b1;
    pipe_idle = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00000000; in_pc = 64'h6000;
    tick();
    in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    nChecks++;
    if ({out_valid, illegal, in_ready} !== 3'b010) begin
      nFail++;
      $display("FAIL ill_flag got v=%b ill=%b rdy=%b exp 0 1 0",
               out_valid, illegal, in_ready);
    end
    tick();
    nChecks++;
    if (halted !== 1'b1) begin
      nFail++;
      $display("FAIL ill_halt got %b exp 1", halted);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    nChecks++;
    if ({illegal, halted} !== 2'b10) begin
      nFail++;
      $display("FAIL ill_sticky got ill=%b h=%b exp ill=1 h=0", illegal, halted);
    end
`else
    nChecks++;
    if ({out_valid, out_ctrl, out_pc} !== {1'b1, 12'h000, 64'h6000}) begin
      nFail++;
      $display("FAIL nop_emit got v=%b c=%h pc=%h exp v=1 c=000 pc=6000",
               out_valid, out_ctrl, out_pc);
    end
    tick();
    nChecks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      nFail++;
      $display("FAIL nop_run got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    pipe_idle = 1'b0;
    resume    = 1'b0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_halt();
    test_flush();
    test_reset_drain();
    test_unmatched();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
